rv32_pc_sequencer: RTL and testbench
====================================

# rv32_pc_sequencer

Per-hart program-counter store and round-robin fetch issuer for the barrel pipeline. It sits between the next-PC calculation and instruction memory. Each cycle it selects one hart slot and presents that hart's PC to instruction memory, then advances the stored PC by 4. Redirects returning from the execute stage (branch taken, JAL/JALR, MRET, IRQ entry) overwrite the target hart's stored PC.

## Interface
Parameters:
- NUM_HARTS, 8, number of hart slots; power of two, 2..16
- PC_W, 32, byte-address PC width
- IMEM_AW, 12, instruction memory word-address width
- RESET_PC, 32'h0, PC loaded into every hart at reset; must be word aligned

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- hart_en  in  NUM_HARTS  per-hart run enable; bit h=0 suppresses fetch in slot h
- stall  in  1  back-pressure from the fetch/decode path; freezes issue
- upd_valid  in  1  redirect/update from the execute stage is present this cycle
- upd_hart_id  in  log2(NUM_HARTS)  hart the update belongs to
- upd_has_new_pc  in  1  1 = replace the PC with upd_next_pc; 0 = no change
- upd_next_pc  in  PC_W  target PC from the next-PC stage
- fetch_valid  out  1  fetch request valid
- fetch_hart_id  out  log2(NUM_HARTS)  hart of the current fetch
- fetch_pc  out  PC_W  byte PC of the fetched instruction, passed down the pipe
- imem_addr  out  IMEM_AW  word address, equal to fetch_pc[IMEM_AW+1:2]
- misalign_err  out  NUM_HARTS  sticky per-hart flag: a redirect target had bits [1:0] != 0

## Operation
- State:
  - pc_q[NUM_HARTS] of PC_W bits
  - slot counter, log2(NUM_HARTS) bits
  - registered fetch outputs
  - misalign_err register
- Issue, when stall=0, each cycle:
  - Slot h = current counter value.
  - Outputs register the following: fetch_hart_id=h, fetch_pc=pc_eff[h], imem_addr derived from fetch_pc, fetch_valid=hart_en[h].
  - If hart_en[h]=1, pc_q[h] <= pc_eff[h]+4, with modulo 2^PC_W wrap.
  - If hart_en[h]=0, pc_q[h] keeps pc_eff[h]. The slot is still consumed.
  - The counter increments and wraps from NUM_HARTS-1 to 0.
- pc_eff[h] is upd_next_pc with bits [1:0] forced to 0 when upd_valid & upd_has_new_pc & upd_hart_id==h. Otherwise pc_eff[h] = pc_q[h]. This means a same-cycle redirect is forwarded into the issue.
- Redirect, applied whether or not stall is asserted:
  - On upd_valid & upd_has_new_pc, pc_q[upd_hart_id] <= upd_next_pc with bits [1:0] cleared, unless the same hart is issuing this cycle; in that case the issue rule writes target+4.
  - If upd_next_pc[1:0]!=0, set misalign_err[upd_hart_id]. The flag clears only on rst.
- Redirects with upd_valid=1 and upd_has_new_pc=0 change nothing.
- Stall=1:
  - The counter, the fetch outputs and the non-redirected pc_q values hold.
  - fetch_valid holds its value. The consumer must treat a held request as the same request, not a new one.
- Disabled hart: its PC is frozen. Re-enabling resumes fetch from the frozen PC at that hart's next slot.

## Timing
- Reset values:
  - pc_q[all] = RESET_PC; counter = 0
  - fetch_valid = 0, fetch_hart_id = 0, fetch_pc = 0, imem_addr = 0
  - misalign_err = 0
- Issue latency: the first rising edge with rst=0 and stall=0 registers slot 0. fetch_valid can first be 1 in the cycle after that edge.
- Redirect latency:
  - An update sampled at edge N is visible in pc_q after edge N.
  - If the target hart's slot issues at edge N, the fetch carries the new target (zero-cycle forward).
- Steady state: hart h issues every NUM_HARTS cycles when stall=0.
- rst asserted mid-operation:
  - All state returns to reset values at that edge.
  - Pending updates in the same cycle are discarded.
- Wrap: pc 32'hFFFF_FFFC + 4 = 32'h0. No flag is raised.

## Test plan
- Reset release, hart_en=8'hFF, RESET_PC=0, no stall:
  - Cycles 1..8 show fetch_hart_id 0..7, all with fetch_pc=0.
  - Cycles 9..16 show hart 0..7 with fetch_pc=4.
  - imem_addr = fetch_pc>>2.
- Redirect hart 3 to 32'h0000_0100 while slot 5 issues:
  - Hart 3's next fetch is 0x100, followed by 0x104 one round later.
  - The other harts are unaffected.
- Same-cycle forward: redirect hart 2 to 0x200 on the edge where slot 2 issues:
  - fetch_pc=0x200.
  - Hart 2's next round shows 0x204.
- stall held for 3 cycles while slot 4 is presented:
  - Outputs are unchanged for 3 cycles; pc_q[4] does not advance.
  - A redirect to hart 6 during the stall lands; hart 6 later fetches the target.
- hart_en=8'b1111_1101:
  - Slot 1 shows fetch_valid=0 and pc_q[1] stays constant.
  - Setting bit 1 resumes hart 1 at the frozen PC.
- Redirect hart 7 to 0x0000_0102:
  - misalign_err[7]=1 and stays set.
  - Hart 7 fetches 0x100.
  - Asserting rst clears the flag and returns every PC to RESET_PC.

Source files
------------

// File: rtl/rv32_pc_sequencer.sv
// Per-hart PC store with round-robin fetch issue; a fetch is registered one edge after its slot is selected.
// Stall freezes the slot counter, the fetch outputs and issue-side PC advance, but redirects still land in the PC store.
module rv32_pc_sequencer #(
  parameter int              NUM_HARTS = 8,
  parameter int              PC_W      = 32,
  parameter int              IMEM_AW   = 12,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_HARTS-1:0]         hart_en,
  input  logic                         stall,
  input  logic                         upd_valid,
  input  logic [$clog2(NUM_HARTS)-1:0] upd_hart_id,
  input  logic                         upd_has_new_pc,
  input  logic [PC_W-1:0]              upd_next_pc,
  output logic                         fetch_valid,
  output logic [$clog2(NUM_HARTS)-1:0] fetch_hart_id,
  output logic [PC_W-1:0]              fetch_pc,
  output logic [IMEM_AW-1:0]           imem_addr,
  output logic [NUM_HARTS-1:0]         misalign_err
);

  localparam int HID_W = $clog2(NUM_HARTS);

  typedef struct packed {
    logic             vld;
    logic [HID_W-1:0] hart_id;
    logic [PC_W-1:0]  pc;
  } fetch_t;

  logic [PC_W-1:0]      pc_q   [NUM_HARTS];
  logic [PC_W-1:0]      pc_eff [NUM_HARTS];
  logic [HID_W-1:0]     slot_q;
  fetch_t               fetch_q;
  logic [NUM_HARTS-1:0] misalign_q;
  logic                 redirect;
  logic [PC_W-1:0]      target;

  assign redirect = upd_valid & upd_has_new_pc;
  assign target   = {upd_next_pc[PC_W-1:2], 2'b00};

  // A redirect for the issuing hart is forwarded so the fetch carries the new target.
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      pc_eff[h] = (redirect && (upd_hart_id == HID_W'(h))) ? target : pc_q[h];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        pc_q[h] <= RESET_PC;
      end
      slot_q     <= '0;
      fetch_q    <= '0;
      misalign_q <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (!stall && (slot_q == HID_W'(h)) && hart_en[h]) begin
          pc_q[h] <= pc_eff[h] + PC_W'(4);
        end else begin
          pc_q[h] <= pc_eff[h];
        end
      end
      if (!stall) begin
        fetch_q.vld     <= hart_en[slot_q];
        fetch_q.hart_id <= slot_q;
        fetch_q.pc      <= pc_eff[slot_q];
        slot_q          <= slot_q + HID_W'(1);
      end
      if (redirect && (upd_next_pc[1:0] != 2'b00)) begin
        misalign_q[upd_hart_id] <= 1'b1;
      end
    end
  end

  assign fetch_valid   = fetch_q.vld;
  assign fetch_hart_id = fetch_q.hart_id;
  assign fetch_pc      = fetch_q.pc;
  assign imem_addr     = fetch_q.pc[IMEM_AW+1:2];
  assign misalign_err  = misalign_q;

endmodule

// File: tb/tb_rv32_pc_sequencer.sv
// Bench for rv32_pc_sequencer: directed vector table, hand-written corner sequences and a random run against a reference model.
module tb_rv32_pc_sequencer;
  localparam int NH = 8;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst, stall, upd_valid, upd_has_new_pc;
  logic [7:0]  hart_en;
  logic [2:0]  upd_hart_id;
  logic [31:0] upd_next_pc;
  logic        fetch_valid;
  logic [2:0]  fetch_hart_id;
  logic [31:0] fetch_pc;
  logic [11:0] imem_addr;
  logic [7:0]  misalign_err;

  always #5 clk = ~clk;

  rv32_pc_sequencer #(.NUM_HARTS(NH), .PC_W(32), .IMEM_AW(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .hart_en(hart_en), .stall(stall),
    .upd_valid(upd_valid), .upd_hart_id(upd_hart_id), .upd_has_new_pc(upd_has_new_pc),
    .upd_next_pc(upd_next_pc), .fetch_valid(fetch_valid), .fetch_hart_id(fetch_hart_id),
    .fetch_pc(fetch_pc), .imem_addr(imem_addr), .misalign_err(misalign_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a PC array per hart, a slot index and the last issued request.
  logic [31:0] m_pc [NH];
  int          m_slot;
  logic        m_vld;
  logic [2:0]  m_hart;
  logic [31:0] m_fpc;
  logic [7:0]  m_err;

  typedef struct {
    logic        uv;
    logic [2:0]  uh;
    logic [31:0] upc;
    logic        exp_vld;
    logic [2:0]  exp_hart;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int h = 0; h < NH; h++) m_pc[h] = 32'h0;
      m_slot = 0; m_vld = 1'b0; m_hart = 3'd0; m_fpc = 32'h0; m_err = 8'h0;
    end else begin
      if (upd_valid && upd_has_new_pc) begin
        if (upd_next_pc % 4 != 0) m_err[upd_hart_id] = 1'b1;
        m_pc[upd_hart_id] = upd_next_pc - (upd_next_pc % 4);
      end
      if (!stall) begin
        m_vld  = hart_en[m_slot];
        m_hart = 3'(m_slot);
        m_fpc  = m_pc[m_slot];
        if (hart_en[m_slot]) m_pc[m_slot] = m_pc[m_slot] + 32'd4;
        m_slot = (m_slot + 1) % NH;
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [7:0] en, input logic uv,
                      input logic [2:0] uh, input logic has, input logic [31:0] upc);
    rst = r; stall = s; hart_en = en; upd_valid = uv;
    upd_hart_id = uh; upd_has_new_pc = has; upd_next_pc = upc;
    @(posedge clk);
    model_edge();
    #1;
    check("model_vld",  32'(fetch_valid),   32'(m_vld));
    check("model_hart", 32'(fetch_hart_id), 32'(m_hart));
    check("model_pc",   fetch_pc,           m_fpc);
    check("model_imem", 32'(imem_addr),     32'(m_fpc[AW+1:2]));
    check("model_err",  32'(misalign_err),  32'(m_err));
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [7:0] en);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, en, 1'b0, 3'd0, 1'b0, 32'h0);
  endtask

  initial begin
    // Four rounds from reset; redirects for hart 3 (during slot 5) and hart 2 (same-cycle forward).
    for (int i = 0; i < 32; i++) begin
      tbl[i].uv = 1'b0; tbl[i].uh = 3'd0; tbl[i].upc = 32'h0;
      tbl[i].exp_vld = 1'b1; tbl[i].exp_hart = 3'(i % 8); tbl[i].exp_pc = 32'(4 * (i / 8));
    end
    tbl[13].uv = 1'b1; tbl[13].uh = 3'd3; tbl[13].upc = 32'h0000_0100;
    tbl[19].exp_pc = 32'h100;
    tbl[27].exp_pc = 32'h104;
    tbl[18].uv = 1'b1; tbl[18].uh = 3'd2; tbl[18].upc = 32'h0000_0200;
    tbl[18].exp_pc = 32'h200;
    tbl[26].exp_pc = 32'h204;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 32'h0);
    check("reset_vld", 32'(fetch_valid), 32'h0);
    check("reset_pc",  fetch_pc,         32'h0);
    check("reset_err", 32'(misalign_err), 32'h0);

    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 8'hFF, tbl[i].uv, tbl[i].uh, tbl[i].uv, tbl[i].upc);
      check($sformatf("tbl%0d_vld", i),  32'(fetch_valid),   32'(tbl[i].exp_vld));
      check($sformatf("tbl%0d_hart", i), 32'(fetch_hart_id), 32'(tbl[i].exp_hart));
      check($sformatf("tbl%0d_pc", i),   fetch_pc,           tbl[i].exp_pc);
      check($sformatf("tbl%0d_imem", i), 32'(imem_addr),     32'(tbl[i].exp_pc[13:2]));
    end

    // Stall while slot 4 is presented; redirect hart 6 during the stall.
    idle(5, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hFF, i == 0, 3'd6, 1'b1, 32'h0000_0600);
      check("stall_hart", 32'(fetch_hart_id), 32'd4);
      check("stall_pc",   fetch_pc,           32'h10);
      check("stall_vld",  32'(fetch_valid),   32'h1);
    end
    idle(2, 8'hFF);
    check("stall_redir_hart", 32'(fetch_hart_id), 32'd6);
    check("stall_redir_pc",   fetch_pc,           32'h600);
    idle(6, 8'hFF);
    check("stall_h4_next", fetch_pc, 32'h14);
    idle(3, 8'hFF);

    // Hart 1 disabled for two rounds, then resumed at its frozen PC.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 8'hFD, 1'b0, 3'd0, 1'b0, 32'h0);
      if (i % 8 == 1) begin
        check("dis_vld", 32'(fetch_valid), 32'h0);
        check("dis_pc",  fetch_pc,         32'h18);
      end
    end
    idle(2, 8'hFF);
    check("reen_vld", 32'(fetch_valid), 32'h1);
    check("reen_pc",  fetch_pc,         32'h18);

    // Misaligned redirect on hart 7 (issued at slot 2, not hart 7's slot).
    step(1'b0, 1'b0, 8'hFF, 1'b1, 3'd7, 1'b1, 32'h0000_0102);
    check("mis_flag", 32'(misalign_err), 32'h80);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 32'h0);
      if (fetch_hart_id == 3'd7) check("mis_pc", fetch_pc, 32'h100);
    end
    check("mis_sticky", 32'(misalign_err), 32'h80);

    // Reset with a pending redirect: flag clears, the redirect is discarded.
    step(1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 32'h0000_0040);
    check("rst_err", 32'(misalign_err), 32'h0);
    check("rst_vld", 32'(fetch_valid),  32'h0);
    step(1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 32'h0);
    check("rst_h0_pc", fetch_pc, 32'h0);

    // PC wrap: hart 0 redirected to the top of the address space.
    idle(7, 8'hFF);
    step(1'b0, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_first", fetch_pc, 32'hFFFF_FFFC);
    idle(8, 8'hFF);
    check("wrap_hart",   32'(fetch_hart_id), 32'd0);
    check("wrap_second", fetch_pc,           32'h0);
    check("wrap_noflag", 32'(misalign_err),  32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      step($urandom_range(199) == 0, $urandom_range(3) == 0,
           ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF,
           $urandom_range(2) == 0, 3'($urandom), 1'($urandom), rpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
